branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Multi-cycle, parametrised branch resolution for the RV64 core. Accepts one
//  conditional branch (operands, funct3, PC, immediate, predicted direction),
//  compares operands CHUNK_W bits per cycle, MSB chunk first, and returns
//  taken, target, redirect PC and mispredict. Sits between EX operand
//  forwarding and the fetch redirect path. Replaces the single-cycle
//  comparator on wide datapaths where a full-width compare misses timing.
// PARAMETERS
//  DATA_W   64  operand width in bits; must be a multiple of CHUNK_W
//  CHUNK_W  16  bits compared per cycle; NCHUNK = DATA_W/CHUNK_W, NCHUNK >= 1
//  ADDR_W   64  PC / target width in bits
// PORTS
//  clk           in   1        rising-edge clock
//  rst_n         in   1        asynchronous, active-low reset
//  flush         in   1        synchronous kill of the in-flight branch
//  in_valid      in   1        request valid
//  in_ready      out  1        unit can accept a request
//  in_a          in   DATA_W   rs1 value
//  in_b          in   DATA_W   rs2 value
//  in_funct3     in   3        branch type (RISC-V encoding)
//  in_pc         in   ADDR_W   branch PC
//  in_imm        in   ADDR_W   sign-extended B-immediate
//  in_pred_taken in   1        fetch-stage prediction
//  out_valid     out  1        result valid
//  out_ready     in   1        consumer accepts the result
//  out_taken     out  1        branch resolved taken
//  out_target    out  ADDR_W   in_pc + in_imm, modulo 2^ADDR_W
//  out_redirect  out  ADDR_W   out_taken ? out_target : in_pc + 4
//  out_mispred   out  1        out_taken != in_pred_taken (0 when illegal)
//  out_illegal   out  1        funct3 is 010 or 011
// BEHAVIOUR
//  Reset: FSM=IDLE; in_ready=1; out_valid=0; all other outputs and regs = 0.
//  FSM IDLE -> CMP on in_valid&&in_ready: latch all inputs; chunk idx=NCHUNK-1
//   (MSB chunk); eq_r=1; lt_r=0. in_ready=1 only in IDLE.
//  CMP: one chunk per cycle, idx decrements. If eq_r and chunks differ:
//   eq_r<=0; lt_r<=(a_chk<b_chk). In the MSB chunk, for signed types
//   (funct3[1]=0), compare with the chunk MSB inverted. Once eq_r=0, later
//   chunks do not change eq_r or lt_r. Fixed NCHUNK cycles, no early exit.
//   After chunk 0: -> DONE.
//  DONE: out_valid=1, outputs held stable until out_valid&&out_ready, then
//   -> IDLE. No accept in the same cycle (one bubble per branch).
//  Latency: out_valid rises exactly NCHUNK cycles after the accept edge.
//   Throughput: one branch per NCHUNK+2 cycles with out_ready=1.
//  Decode: 000 BEQ eq; 001 BNE !eq; 100 BLT lt; 101 BGE !lt; 110 BLTU lt;
//   111 BGEU !lt (lt is unsigned for 11x). 010/011: taken=0, illegal=1.
//  Arithmetic: target and pc+4 wrap modulo 2^ADDR_W; no overflow flag.
//  Output regs are updated only on the transition into DONE.
//  flush: in CMP or DONE -> IDLE on the next edge; out_valid=0 next cycle;
//   the result is discarded. A flush in the accept cycle cancels that accept.
//   flush in IDLE has no effect. flush has priority over out_ready.
//  Reset asserted mid-operation: immediate return to the reset state; the
//   branch is lost.
//  Input ports are don't-care outside the accept cycle.
// TESTING
//  T1 BEQ a=b=64'h1234 -> after 4 cycles out_valid=1, taken=1,
//   target=pc+imm, mispred = !pred_taken.
//  T2 BLT a=64'hFFFF..FF(-1), b=1 -> taken=1. BLTU same operands -> taken=0.
//   BGEU same operands -> taken=1.
//  T3 Difference only in chunk 0 (a=5, b=6, BLT) -> taken=1.
//   Difference only in the MSB chunk overrides lower chunks
//   (a=64'h0001_0000_0000_0000, b=64'h0000_FFFF_FFFF_FFFF, BGE) -> taken=1.
//  T4 Backpressure: out_ready=0 for 5 cycles -> outputs stable, in_ready=0;
//   release -> IDLE, next accept one cycle later.
//  T5 flush on cycle 2 of CMP -> out_valid never rises, in_ready=1 the next
//   cycle. rst_n low mid-CMP -> all outputs 0 asynchronously.
//  T6 funct3=010 -> out_illegal=1, taken=0, mispred=0. pc=2^64-4, imm=8 ->
//   target=4 (wrap). Repeat T1-T3 with CHUNK_W=64 (latency 1).

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Multi-cycle conditional branch resolver: compares rs1/rs2 CHUNK_W bits per cycle,
// MSB chunk first, then presents taken/target/redirect/mispredict for one handshake.
module branch_resolve_unit #(
    parameter int DATA_W  = 64,
    parameter int CHUNK_W = 16,
    parameter int ADDR_W  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [2:0]        in_funct3,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [ADDR_W-1:0] in_imm,
    input  logic              in_pred_taken,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_taken,
    output logic [ADDR_W-1:0] out_target,
    output logic [ADDR_W-1:0] out_redirect,
    output logic              out_mispred,
    output logic              out_illegal
);

    localparam int NCHUNK = DATA_W / CHUNK_W;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0]  IDX_MSB = IDX_W'(NCHUNK - 1);
    localparam logic [ADDR_W-1:0] SEQ_INC = ADDR_W'(4);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              state_q;
    logic [DATA_W-1:0]   a_q, b_q;
    logic [2:0]          funct3_q;
    logic [ADDR_W-1:0]   pc_q, imm_q;
    logic                pred_q;
    logic [IDX_W-1:0]    idx_q;
    logic                eq_q, lt_q;
    logic                taken_q, mispred_q, illegal_q;
    logic [ADDR_W-1:0]   target_q, redirect_q;

    logic [CHUNK_W-1:0]  a_chk, b_chk;
    logic                eq_d, lt_d, taken_d, illegal_d, mispred_d;
    logic [ADDR_W-1:0]   target_d, redirect_d;

    // Operands are shifted left each cycle, so the chunk under test is always the top one.
    always_comb begin
        a_chk = a_q[DATA_W-1 -: CHUNK_W];
        b_chk = b_q[DATA_W-1 -: CHUNK_W];
        // Flipping the sign bit turns a signed compare into an unsigned one.
        if ((idx_q == IDX_MSB) && !funct3_q[1]) begin
            a_chk[CHUNK_W-1] = ~a_chk[CHUNK_W-1];
            b_chk[CHUNK_W-1] = ~b_chk[CHUNK_W-1];
        end
        eq_d = eq_q;
        lt_d = lt_q;
        if (eq_q && (a_chk != b_chk)) begin
            eq_d = 1'b0;
            lt_d = (a_chk < b_chk);
        end

        illegal_d = (funct3_q[2:1] == 2'b01);
        case (funct3_q)
            3'b000:  taken_d = eq_d;
            3'b001:  taken_d = ~eq_d;
            3'b100:  taken_d = lt_d;
            3'b101:  taken_d = ~lt_d;
            3'b110:  taken_d = lt_d;
            3'b111:  taken_d = ~lt_d;
            default: taken_d = 1'b0;
        endcase
        mispred_d  = ~illegal_d & (taken_d ^ pred_q);
        target_d   = pc_q + imm_q;
        redirect_d = taken_d ? target_d : (pc_q + SEQ_INC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            funct3_q   <= '0;
            pc_q       <= '0;
            imm_q      <= '0;
            pred_q     <= 1'b0;
            idx_q      <= '0;
            eq_q       <= 1'b0;
            lt_q       <= 1'b0;
            taken_q    <= 1'b0;
            target_q   <= '0;
            redirect_q <= '0;
            mispred_q  <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && !flush) begin
                        a_q      <= in_a;
                        b_q      <= in_b;
                        funct3_q <= in_funct3;
                        pc_q     <= in_pc;
                        imm_q    <= in_imm;
                        pred_q   <= in_pred_taken;
                        idx_q    <= IDX_MSB;
                        eq_q     <= 1'b1;
                        lt_q     <= 1'b0;
                        state_q  <= S_CMP;
                    end
                end
                S_CMP: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        a_q   <= a_q << CHUNK_W;
                        b_q   <= b_q << CHUNK_W;
                        eq_q  <= eq_d;
                        lt_q  <= lt_d;
                        idx_q <= idx_q - IDX_W'(1);
                        if (idx_q == '0) begin
                            taken_q    <= taken_d;
                            target_q   <= target_d;
                            redirect_q <= redirect_d;
                            mispred_q  <= mispred_d;
                            illegal_q  <= illegal_d;
                            state_q    <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (flush || out_ready) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready     = (state_q == S_IDLE);
    assign out_valid    = (state_q == S_DONE);
    assign out_taken    = taken_q;
    assign out_target   = target_q;
    assign out_redirect = redirect_q;
    assign out_mispred  = mispred_q;
    assign out_illegal  = illegal_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a 16-bit-chunk instance (latency 4)
// and a full-width instance (latency 1) sharing operand inputs.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst_n, flush;
    logic [63:0] in_a, in_b, in_pc, in_imm;
    logic [2:0]  in_funct3;
    logic        in_pred_taken;

    logic        iv_n, ir_n, ov_n, or_n, tk_n, mp_n, il_n;
    logic [63:0] tg_n, rd_n;
    logic        iv_w, ir_w, ov_w, or_w, tk_w, mp_w, il_w;
    logic [63:0] tg_w, rd_w;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.DATA_W(64), .CHUNK_W(16), .ADDR_W(64)) dut_n (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(iv_n), .in_ready(ir_n),
        .in_a(in_a), .in_b(in_b), .in_funct3(in_funct3), .in_pc(in_pc),
        .in_imm(in_imm), .in_pred_taken(in_pred_taken),
        .out_valid(ov_n), .out_ready(or_n), .out_taken(tk_n),
        .out_target(tg_n), .out_redirect(rd_n), .out_mispred(mp_n), .out_illegal(il_n)
    );

    branch_resolve_unit #(.DATA_W(64), .CHUNK_W(64), .ADDR_W(64)) dut_w (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(iv_w), .in_ready(ir_w),
        .in_a(in_a), .in_b(in_b), .in_funct3(in_funct3), .in_pc(in_pc),
        .in_imm(in_imm), .in_pred_taken(in_pred_taken),
        .out_valid(ov_w), .out_ready(or_w), .out_taken(tk_w),
        .out_target(tg_w), .out_redirect(rd_w), .out_mispred(mp_w), .out_illegal(il_w)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one branch, wait for the result with a bounded loop, check everything.
    task automatic run(input bit wide, input string tag,
                       input logic [63:0] a, input logic [63:0] b, input logic [2:0] f3,
                       input logic [63:0] pc, input logic [63:0] imm, input logic pred,
                       input logic e_tk, input logic [63:0] e_tg, input logic [63:0] e_rd,
                       input logic e_mp, input logic e_il);
        int lat;
        @(negedge clk);
        in_a = a; in_b = b; in_funct3 = f3; in_pc = pc; in_imm = imm; in_pred_taken = pred;
        if (wide) iv_w = 1'b1; else iv_n = 1'b1;
        @(negedge clk);
        iv_n = 1'b0; iv_w = 1'b0;
        lat = 0;
        while (!(wide ? ov_w : ov_n) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".lat"},   64'(lat), wide ? 64'd1 : 64'd4);
        check({tag, ".taken"}, 64'(wide ? tk_w : tk_n), 64'(e_tk));
        check({tag, ".tgt"},   wide ? tg_w : tg_n, e_tg);
        check({tag, ".redir"}, wide ? rd_w : rd_n, e_rd);
        check({tag, ".mis"},   64'(wide ? mp_w : mp_n), 64'(e_mp));
        check({tag, ".ill"},   64'(wide ? il_w : il_n), 64'(e_il));
        @(negedge clk);
        check({tag, ".idle"},  64'({wide ? ov_w : ov_n, wide ? ir_w : ir_n}), 64'b01);
    endtask

    localparam logic [63:0] M1   = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] NEG8 = 64'hFFFF_FFFF_FFFF_FFF8;
    localparam logic [63:0] PCW  = 64'hFFFF_FFFF_FFFF_FFFC;

    initial begin
        int lat;
        bit seen;
        rst_n = 1'b0; flush = 1'b0; iv_n = 1'b0; iv_w = 1'b0; or_n = 1'b1; or_w = 1'b1;
        in_a = '0; in_b = '0; in_funct3 = '0; in_pc = '0; in_imm = '0; in_pred_taken = 1'b0;
        #1;
        check("rst.in_ready",  64'(ir_n), 64'd1);
        check("rst.out_valid", 64'(ov_n), 64'd0);
        check("rst.outs",      64'({tk_n, mp_n, il_n}), 64'd0);
        check("rst.target",    tg_n | rd_n, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // T1-T3 on the chunked instance
        run(0, "beq",   64'h1234, 64'h1234, 3'b000, 64'h1000, 64'h40, 1'b0, 1, 64'h1040, 64'h1040, 1, 0);
        run(0, "blt_m1", M1, 64'd1, 3'b100, 64'h2000, NEG8, 1'b1, 1, 64'h1FF8, 64'h1FF8, 0, 0);
        run(0, "bltu_m1", M1, 64'd1, 3'b110, 64'h2000, NEG8, 1'b1, 0, 64'h1FF8, 64'h2004, 1, 0);
        run(0, "bgeu_m1", M1, 64'd1, 3'b111, 64'h2000, NEG8, 1'b0, 1, 64'h1FF8, 64'h1FF8, 1, 0);
        run(0, "blt_c0", 64'd5, 64'd6, 3'b100, 64'h100, 64'h8, 1'b1, 1, 64'h108, 64'h108, 0, 0);
        run(0, "bge_msb", 64'h0001_0000_0000_0000, 64'h0000_FFFF_FFFF_FFFF, 3'b101,
            64'h100, 64'h8, 1'b0, 1, 64'h108, 64'h108, 1, 0);
        run(0, "bge_neg", 64'h8000_0000_0000_0000, 64'd0, 3'b101,
            64'h100, 64'h8, 1'b1, 0, 64'h108, 64'h104, 1, 0);
        run(0, "bne_eq", 64'hDEAD, 64'hDEAD, 3'b001, 64'h100, 64'h8, 1'b0, 0, 64'h108, 64'h104, 0, 0);

        // T6 illegal and wraparound
        run(0, "illegal", 64'd1, 64'd2, 3'b010, 64'h500, 64'h10, 1'b1, 0, 64'h510, 64'h504, 0, 1);
        run(0, "wrap_tk", 64'd0, 64'd0, 3'b000, PCW, 64'h8, 1'b1, 1, 64'h4, 64'h4, 0, 0);
        run(0, "wrap_nt", 64'd3, 64'd3, 3'b001, PCW, 64'h8, 1'b0, 0, 64'h4, 64'h0, 0, 0);

        // T4 backpressure
        or_n = 1'b0;
        @(negedge clk);
        in_a = 64'd7; in_b = 64'd7; in_funct3 = 3'b000; in_pc = 64'h3000; in_imm = 64'h10;
        in_pred_taken = 1'b1; iv_n = 1'b1;
        @(negedge clk);
        iv_n = 1'b0;
        lat = 0;
        while (!ov_n && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("bp.lat", 64'(lat), 64'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp.hold_valid", 64'({ov_n, ir_n}), 64'b10);
            check("bp.hold_tgt", tg_n, 64'h3010);
            check("bp.hold_tk", 64'({tk_n, mp_n}), 64'b10);
        end
        or_n = 1'b1;
        @(negedge clk);
        check("bp.release", 64'({ov_n, ir_n}), 64'b01);
        in_a = 64'd1; in_b = 64'd2; in_funct3 = 3'b001; in_pc = 64'h4000; in_imm = 64'h20;
        in_pred_taken = 1'b1; iv_n = 1'b1;
        @(negedge clk);
        iv_n = 1'b0;
        check("bp.reaccept", 64'(ir_n), 64'd0);
        lat = 0;
        while (!ov_n && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("bp2.lat", 64'(lat), 64'd4);
        check("bp2.tgt", rd_n, 64'h4020);
        @(negedge clk);

        // T5 flush on CMP cycle 2
        in_a = 64'd9; in_b = 64'd9; in_funct3 = 3'b000; in_pc = 64'h6000; in_imm = 64'h4;
        iv_n = 1'b1;
        @(negedge clk);
        iv_n = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush.idle", 64'({ov_n, ir_n}), 64'b01);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen |= ov_n;
        end
        check("flush.no_valid", 64'(seen), 64'd0);
        check("flush.keep_prev", tg_n, 64'h4020);

        // flush in the accept cycle cancels the accept
        iv_n = 1'b1; flush = 1'b1;
        @(negedge clk);
        iv_n = 1'b0; flush = 1'b0;
        check("flush.accept", 64'(ir_n), 64'd1);

        // asynchronous reset mid-CMP
        iv_n = 1'b1;
        @(negedge clk);
        iv_n = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst.state", 64'({ov_n, ir_n}), 64'b01);
        check("arst.outs", 64'({tk_n, mp_n, il_n}), 64'd0);
        check("arst.tgt", tg_n | rd_n, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // T1-T3 on the full-width instance
        run(1, "w.beq", 64'h1234, 64'h1234, 3'b000, 64'h1000, 64'h40, 1'b0, 1, 64'h1040, 64'h1040, 1, 0);
        run(1, "w.blt_m1", M1, 64'd1, 3'b100, 64'h2000, NEG8, 1'b1, 1, 64'h1FF8, 64'h1FF8, 0, 0);
        run(1, "w.bltu_m1", M1, 64'd1, 3'b110, 64'h2000, NEG8, 1'b1, 0, 64'h1FF8, 64'h2004, 1, 0);
        run(1, "w.bgeu_m1", M1, 64'd1, 3'b111, 64'h2000, NEG8, 1'b0, 1, 64'h1FF8, 64'h1FF8, 1, 0);
        run(1, "w.blt_c0", 64'd5, 64'd6, 3'b100, 64'h100, 64'h8, 1'b1, 1, 64'h108, 64'h108, 0, 0);
        run(1, "w.bge_msb", 64'h0001_0000_0000_0000, 64'h0000_FFFF_FFFF_FFFF, 3'b101,
            64'h100, 64'h8, 1'b0, 1, 64'h108, 64'h108, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
